// File: rtl/dti_uart_rx_pkg.sv
// rtl/dti_uart_rx_pkg.sv - shared types and constants for the dti_uart_rx receiver
package dti_uart_rx_pkg;

  localparam int DEFAULT_OVS = 16;

  localparam logic [1:0] DATA_BITS_5 = 2'b00;
  localparam logic [1:0] DATA_BITS_6 = 2'b01;
  localparam logic [1:0] DATA_BITS_7 = 2'b10;
  localparam logic [1:0] DATA_BITS_8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Index of the last data bit of a frame, i.e. data bit count minus one.
  function automatic logic [2:0] last_data_idx(input logic [1:0] data_bits);
    case (data_bits)
      DATA_BITS_5: return 3'd4;
      DATA_BITS_6: return 3'd5;
      DATA_BITS_7: return 3'd6;
      DATA_BITS_8: return 3'd7;
      default:     return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/dti_uart_baud_tick.sv
// rtl/dti_uart_baud_tick.sv - oversample tick generator, one tick every cfg_div+1 clocks
module dti_uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!en || (div_cnt == cfg_div)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = en && (div_cnt == cfg_div);

endmodule

// File: rtl/dti_uart_rx.sv
// rtl/dti_uart_rx.sv - oversampling UART receiver with valid/ready output and per-frame error flags
// Optional 3-sample majority vote per bit: DTI_UART_RX_MAJORITY_VOTE_EN.
module dti_uart_rx
  import dti_uart_rx_pkg::*;
#(
  parameter int OVS   = DEFAULT_OVS,
  parameter int DIV_W = 16
) (
  input  logic             uart_clk,
  input  logic             reset_n,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_parity_en,
  input  logic             cfg_parity_even,
  input  logic             cfg_stop_2,
  input  logic             uart_rxd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             break_det,
  output logic             overrun_err
);

  // One spare bit so the vote variant can count to mid+1 of a full bit.
  localparam int CNT_W = $clog2(OVS) + 1;
  localparam logic [CNT_W-1:0] START_MID = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_MID   = CNT_W'(OVS - 1);

  logic [1:0]       sync_q;
  logic             rxd_s;
  logic             tick;

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] samp_cnt, samp_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift_q, shift_nxt;
  logic             par_bit_q, par_bit_nxt;
  logic             par_err_q, par_err_nxt;
  logic             frm_err_q, frm_err_nxt;
  logic             stop_idx_q, stop_idx_nxt;
  logic             frame_done;
  logic             frame_brk;

  logic [CNT_W-1:0] mid_cnt;
  logic             decide;
  logic             bit_val;
  logic             par_exp;

  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rxd};
    end
  end

  assign rxd_s = sync_q[1];

  dti_uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk     (uart_clk),
    .rst_n   (reset_n),
    .en      (rx_en),
    .cfg_div (cfg_div),
    .tick    (tick)
  );

  assign mid_cnt = (state == ST_START) ? START_MID : BIT_MID;

`ifdef DTI_UART_RX_MAJORITY_VOTE_EN
  // Decision lands one tick after mid, so the counter restarts at 1 to keep bit spacing.
  localparam logic [CNT_W-1:0] CNT_RESTART = CNT_W'(1);

  logic [1:0] vote_q;

  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      vote_q <= '0;
    end else if (tick) begin
      if (samp_cnt == (mid_cnt - CNT_W'(1))) vote_q[0] <= rxd_s;
      if (samp_cnt == mid_cnt)               vote_q[1] <= rxd_s;
    end
  end

  assign decide  = tick && (state != ST_IDLE) && (samp_cnt == (mid_cnt + CNT_W'(1)));
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s) | (vote_q[1] & rxd_s);
`else
  localparam logic [CNT_W-1:0] CNT_RESTART = '0;

  assign decide  = tick && (state != ST_IDLE) && (samp_cnt == mid_cnt);
  assign bit_val = rxd_s;
`endif

  // Upper shift bits stay 0 for short frames, so a full-width XOR is safe.
  assign par_exp = (^shift_q) ^ ~cfg_parity_even;

  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      stop_idx_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      samp_cnt   <= samp_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_q    <= shift_nxt;
      par_bit_q  <= par_bit_nxt;
      par_err_q  <= par_err_nxt;
      frm_err_q  <= frm_err_nxt;
      stop_idx_q <= stop_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    samp_cnt_nxt = samp_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_q;
    par_bit_nxt  = par_bit_q;
    par_err_nxt  = par_err_q;
    frm_err_nxt  = frm_err_q;
    stop_idx_nxt = stop_idx_q;
    frame_done   = 1'b0;

    if (!rx_en) begin
      state_nxt    = ST_IDLE;
      samp_cnt_nxt = '0;
    end else if (tick) begin
      samp_cnt_nxt = samp_cnt + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          samp_cnt_nxt = '0;
          if (!rxd_s) begin
            state_nxt    = ST_START;
            bit_cnt_nxt  = '0;
            shift_nxt    = '0;
            par_bit_nxt  = 1'b0;
            par_err_nxt  = 1'b0;
            frm_err_nxt  = 1'b0;
            stop_idx_nxt = 1'b0;
          end
        end
        ST_START: begin
          if (decide) begin
            samp_cnt_nxt = bit_val ? '0 : CNT_RESTART;
            state_nxt    = bit_val ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide) begin
            samp_cnt_nxt       = CNT_RESTART;
            shift_nxt[bit_cnt] = bit_val;
            bit_cnt_nxt        = bit_cnt + 3'd1;
            if (bit_cnt == last_data_idx(cfg_data_bits)) begin
              state_nxt = cfg_parity_en ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (decide) begin
            samp_cnt_nxt = CNT_RESTART;
            par_bit_nxt  = bit_val;
            par_err_nxt  = (bit_val != par_exp);
            state_nxt    = ST_STOP;
          end
        end
        ST_STOP: begin
          if (decide) begin
            samp_cnt_nxt = CNT_RESTART;
            frm_err_nxt  = frm_err_q | ~bit_val;
            if (cfg_stop_2 && !stop_idx_q) begin
              stop_idx_nxt = 1'b1;
            end else begin
              samp_cnt_nxt = '0;
              frame_done   = 1'b1;
              state_nxt    = ST_IDLE;
            end
          end
        end
        default: begin
          state_nxt    = ST_IDLE;
          samp_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign frame_brk = frm_err_nxt && (shift_q == 8'h00) && !par_bit_q;

  // A completed frame is dropped only if the held one is not consumed this cycle.
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (frame_done && rx_valid && !rx_ready) begin
      overrun_err <= 1'b1;
    end else if (frame_done) begin
      rx_data     <= shift_q;
      rx_valid    <= 1'b1;
      parity_err  <= par_err_q;
      frame_err   <= frm_err_nxt;
      break_det   <= frame_brk;
      overrun_err <= 1'b0;
    end else if (rx_valid && rx_ready) begin
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dti_uart_rx.sv
// tb/tb_dti_uart_rx.sv - directed self-checking bench for dti_uart_rx
module tb_dti_uart_rx;

  localparam int OVS      = 16;
  localparam int DIV_W    = 16;
  localparam int BIT_CLKS = OVS;

  logic             uart_clk = 1'b0;
  logic             reset_n;
  logic             rx_en;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_data_bits;
  logic             cfg_parity_en;
  logic             cfg_parity_even;
  logic             cfg_stop_2;
  logic             uart_rxd;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             parity_err;
  logic             frame_err;
  logic             break_det;
  logic             overrun_err;

  int         total = 0;
  int         bad   = 0;
  int         vcnt  = 0;
  int         hcnt  = 0;
  logic [7:0] cap_data  = '0;
  logic [3:0] cap_flags = '0;
  int         v0, h0;

  dti_uart_rx #(
    .OVS   (OVS),
    .DIV_W (DIV_W)
  ) dut (
    .uart_clk        (uart_clk),
    .reset_n         (reset_n),
    .rx_en           (rx_en),
    .cfg_div         (cfg_div),
    .cfg_data_bits   (cfg_data_bits),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_parity_even (cfg_parity_even),
    .cfg_stop_2      (cfg_stop_2),
    .uart_rxd        (uart_rxd),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .parity_err      (parity_err),
    .frame_err       (frame_err),
    .break_det       (break_det),
    .overrun_err     (overrun_err)
  );

  always #5 uart_clk = ~uart_clk;

  always @(negedge uart_clk) begin
    if (rx_valid) vcnt++;
    if (rx_valid && rx_ready) begin
      hcnt++;
      cap_data  = rx_data;
      cap_flags = {parity_err, frame_err, break_det, overrun_err};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge uart_clk);
      #1;
    end
  endtask

  task automatic idle_bits(input int n);
    uart_rxd = 1'b1;
    step(n * BIT_CLKS);
  endtask

  // abort_kind: 0 none, 1 drop rx_en mid data bit 3, 2 assert reset there (left asserted)
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input bit par_bit, input bit stop_bit, input int abort_kind);
    logic [11:0] bits;
    int          nb;
    bit          stopped;
    bits    = '0;
    nb      = 0;
    stopped = 1'b0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < nbits; i++) bits[nb++] = d[i];
    if (par_en) bits[nb++] = par_bit;
    bits[nb++] = stop_bit;
    for (int i = 0; i < nb; i++) begin
      if (!stopped) begin
        uart_rxd = bits[i];
        if (abort_kind != 0 && i == 4) begin
          step(BIT_CLKS / 2);
          uart_rxd = 1'b1;
          if (abort_kind == 1) begin
            rx_en = 1'b0;
            step(4);
            rx_en = 1'b1;
          end else begin
            reset_n = 1'b0;
            step(2);
          end
          stopped = 1'b1;
        end else begin
          step(BIT_CLKS);
        end
      end
    end
    uart_rxd = 1'b1;
  endtask

  task automatic set_cfg(input logic [1:0] db, input bit pen, input bit peven);
    cfg_data_bits   = db;
    cfg_parity_en   = pen;
    cfg_parity_even = peven;
    cfg_stop_2      = 1'b0;
  endtask

  task automatic mark();
    v0 = vcnt;
    h0 = hcnt;
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_en    = 1'b0;
    cfg_div  = '0;
    uart_rxd = 1'b1;
    rx_ready = 1'b1;
    set_cfg(2'b11, 1'b0, 1'b0);
    step(3);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_flags", {parity_err, frame_err, break_det, overrun_err}, 4'h0);
    reset_n = 1'b1;
    rx_en   = 1'b1;
    idle_bits(1);

    // 8N1 0xA5
    mark();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(2);
    chk("a5_vcycles", vcnt - v0, 1);
    chk("a5_hs", hcnt - h0, 1);
    chk("a5_data", cap_data, 8'hA5);
    chk("a5_flags", cap_flags, 4'h0);

    // 7E1 0x35: correct parity is 0
    set_cfg(2'b10, 1'b1, 1'b1);
    mark();
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 0);
    idle_bits(2);
    chk("par_bad_hs", hcnt - h0, 1);
    chk("par_bad_data", cap_data, 8'h35);
    chk("par_bad_flags", cap_flags, 4'b1000);
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 0);
    idle_bits(2);
    chk("par_ok_flags", cap_flags, 4'b0000);

    // stop bit low: break with 0x00, plain framing error with 0x41
    set_cfg(2'b11, 1'b0, 1'b0);
    mark();
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 0);
    idle_bits(2);
    chk("brk_hs", hcnt - h0, 1);
    chk("brk_data", cap_data, 8'h00);
    chk("brk_flags", cap_flags, 4'b0110);
    mark();
    send_frame(8'h41, 8, 1'b0, 1'b0, 1'b0, 0);
    idle_bits(2);
    chk("ferr_hs", hcnt - h0, 1);
    chk("ferr_data", cap_data, 8'h41);
    chk("ferr_flags", cap_flags, 4'b0100);

    // overrun
    rx_ready = 1'b0;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(1);
    chk("ovr_first_valid", rx_valid, 1'b1);
    chk("ovr_first_data", rx_data, 8'h11);
    chk("ovr_first_flag", overrun_err, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(1);
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", overrun_err, 1'b1);
    mark();
    rx_ready = 1'b1;
    step(1);
    chk("ovr_hs", hcnt - h0, 1);
    chk("ovr_hs_flags", cap_flags, 4'b0001);
    chk("ovr_hs_data", cap_data, 8'h11);
    chk("ovr_after_valid", rx_valid, 1'b0);
    chk("ovr_after_flags", {parity_err, frame_err, break_det, overrun_err}, 4'h0);

    // 3-tick glitch, then 0x5A
    mark();
    uart_rxd = 1'b0;
    step(3);
    idle_bits(2);
    chk("glitch_none", vcnt - v0, 0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(2);
    chk("glitch_next_hs", hcnt - h0, 1);
    chk("glitch_next_data", cap_data, 8'h5A);

    // rx_en dropped during data bit 3
    mark();
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1);
    idle_bits(2);
    chk("en_abort_none", vcnt - v0, 0);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(2);
    chk("en_next_hs", hcnt - h0, 1);
    chk("en_next_data", cap_data, 8'hC3);

    // reset mid-frame with a frame held in the output register
    rx_ready = 1'b0;
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(1);
    chk("hold_valid", rx_valid, 1'b1);
    chk("hold_data", rx_data, 8'h7E);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 2);
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_valid", rx_valid, 1'b0);
    chk("mrst_flags", {parity_err, frame_err, break_det, overrun_err}, 4'h0);
    reset_n = 1'b1;
    idle_bits(2);
    chk("mrst_no_partial", rx_valid, 1'b0);
    rx_ready = 1'b1;
    mark();
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 0);
    idle_bits(2);
    chk("mrst_next_hs", hcnt - h0, 1);
    chk("mrst_next_data", cap_data, 8'hC3);
    chk("mrst_next_flags", cap_flags, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
